// File: rtl/block_fifo.sv
// block_fifo: complex-sample frame buffer for the FFT datapath.
// Buffers a sample stream and emits gapless frame_len bursts or a partial flush.
module block_fifo #(
    parameter int float_len = 20,
    parameter int addr_len  = 13,
    parameter int frame_len = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2*float_len-1:0] data_in,
    input  logic                   data_in_valid,
    input  logic                   flush,
    output logic [2*float_len-1:0] data_out,
    output logic                   data_out_valid,
    output logic                   data_out_first,
    output logic                   data_out_last,
    output logic [addr_len:0]      data_count,
    output logic                   overflow,
    output logic                   busy
);

    localparam int W     = 2 * float_len;
    localparam int DEPTH = 1 << addr_len;

    localparam logic [addr_len:0] DEPTH_C = DEPTH[addr_len:0];
    localparam logic [addr_len:0] FRAME_C = frame_len[addr_len:0];
    localparam logic [addr_len:0] ONE_C   = {{addr_len{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        FLUSH
    } state_t;

    state_t state;
    state_t state_nx;

    logic [W-1:0]        ram [DEPTH];
    logic [addr_len-1:0] wr_ptr;
    logic [addr_len-1:0] rd_ptr;
    logic [addr_len:0]   burst_cnt;
    logic [addr_len:0]   burst_nx;
    logic [addr_len+1:0] next_avail;
    logic                load;
    logic                first_pend;
    logic                rd_en;
    logic                wr;
    logic                full;
    logic                burst_end;

    assign full      = (data_count == DEPTH_C);
    assign wr        = data_in_valid & ~full;
    assign burst_end = (burst_cnt == ONE_C);

    // Occupancy left once the current read retires, including this cycle's write.
    assign next_avail = {1'b0, data_count}
                      + {{(addr_len+1){1'b0}}, wr}
                      - {1'b0, ONE_C};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        burst_nx = FRAME_C;
        unique case (state)
            IDLE: begin
                if (data_count >= FRAME_C) begin
                    state_nx = BURST;
                    load     = 1'b1;
                end else if (flush && |data_count) begin
                    state_nx = FLUSH;
                    load     = 1'b1;
                    burst_nx = data_count;
                end
            end
            BURST: begin
                if (burst_end) begin
                    if (next_avail >= {1'b0, FRAME_C}) begin
                        load = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            FLUSH: begin
                if (burst_end) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        rd_en = 1'b0;
        unique case (state)
            IDLE:    rd_en = 1'b0;
            BURST:   rd_en = 1'b1;
            FLUSH:   rd_en = 1'b1;
            default: rd_en = 1'b0;
        endcase
    end

    assign busy = rd_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            burst_cnt  <= '0;
            first_pend <= 1'b0;
        end else begin
            first_pend <= load;
            if (load) begin
                burst_cnt <= burst_nx;
            end else if (rd_en) begin
                burst_cnt <= burst_cnt - ONE_C;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            data_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            data_count <= data_count
                        + {{addr_len{1'b0}}, wr}
                        - {{addr_len{1'b0}}, rd_en};
            if (data_in_valid && full) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr) begin
            ram[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out       <= '0;
            data_out_valid <= 1'b0;
            data_out_first <= 1'b0;
            data_out_last  <= 1'b0;
        end else begin
            if (rd_en) begin
                data_out <= ram[rd_ptr];
            end
            data_out_valid <= rd_en;
            data_out_first <= rd_en & first_pend;
            data_out_last  <= rd_en & burst_end;
        end
    end

endmodule

// File: tb/tb_block_fifo.sv
// tb_block_fifo: randomized, model-checked bench for block_fifo.
// Depth 16, frame 8, plus a frame-16 instance for the full/overflow case.
module tb_block_fifo;

    localparam int FL = 20;
    localparam int AL = 4;
    localparam int FR = 8;
    localparam int W  = 2 * FL;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [W-1:0]  data_in = '0;
    logic          data_in_valid = 1'b0;
    logic          flush = 1'b0;
    logic [W-1:0]  data_out;
    logic          data_out_valid;
    logic          data_out_first;
    logic          data_out_last;
    logic [AL:0]   data_count;
    logic          overflow;
    logic          busy;

    logic          data_in_valid2 = 1'b0;
    logic          flush2 = 1'b0;
    logic [W-1:0]  data_out2;
    logic          data_out_valid2;
    logic          data_out_first2;
    logic          data_out_last2;
    logic [AL:0]   data_count2;
    logic          overflow2;
    logic          busy2;

    int vectors = 0;
    int miscompares = 0;
    logic [W-1:0] mq[$];

    always #5 clk = ~clk;

    block_fifo #(.float_len(FL), .addr_len(AL), .frame_len(FR)) dut (
        .clk(clk), .rst(rst), .data_in(data_in),
        .data_in_valid(data_in_valid), .flush(flush),
        .data_out(data_out), .data_out_valid(data_out_valid),
        .data_out_first(data_out_first), .data_out_last(data_out_last),
        .data_count(data_count), .overflow(overflow), .busy(busy)
    );

    block_fifo #(.float_len(FL), .addr_len(AL), .frame_len(16)) dut16 (
        .clk(clk), .rst(rst), .data_in(data_in),
        .data_in_valid(data_in_valid2), .flush(flush2),
        .data_out(data_out2), .data_out_valid(data_out_valid2),
        .data_out_first(data_out_first2), .data_out_last(data_out_last2),
        .data_count(data_count2), .overflow(overflow2), .busy(busy2)
    );

    function automatic logic [W-1:0] smp(input int k);
        logic [FL-1:0] r;
        r = FL'(k);
        return {r, ~r};
    endfunction

    // Drive one cycle of input, then land 1 time unit after the edge.
    task automatic step(input logic v, input logic f, input logic [W-1:0] d);
        data_in_valid = v;
        flush = f;
        data_in = d;
        if (v) mq.push_back(d);
        @(posedge clk);
        #1;
        data_in_valid = 1'b0;
        flush = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        rst = 1'b0;
        mq.delete();
    endtask

    task automatic test_reset;
        do_reset();
        vectors++;
        if ({data_out_valid, data_out_first, data_out_last, overflow,
             busy, data_count, data_out} !== '0) begin
            miscompares++;
            $display("FAIL reset: got v%b f%b l%b o%b b%b cnt%0d d%h, expected all 0",
                     data_out_valid, data_out_first, data_out_last, overflow,
                     busy, data_count, data_out);
        end
        vectors++;
        if ({data_out_valid2, overflow2, busy2, data_count2, data_out2} !== '0) begin
            miscompares++;
            $display("FAIL reset16: got v%b o%b b%b cnt%0d d%h, expected all 0",
                     data_out_valid2, overflow2, busy2, data_count2, data_out2);
        end
    endtask

    task automatic test_basic;
        logic [W-1:0] e;
        do_reset();
        for (int k = 0; k < FR; k++) step(1'b1, 1'b0, smp(k));
        vectors++;
        if ({data_count, busy, data_out_valid} !== {(AL+1)'(FR), 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL basic_n1: got cnt%0d b%b v%b, expected cnt8 b0 v0",
                     data_count, busy, data_out_valid);
        end
        step(1'b0, 1'b0, '0);
        vectors++;
        if ({busy, data_out_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL basic_n2: got b%b v%b, expected b1 v0", busy, data_out_valid);
        end
        for (int k = 0; k < FR; k++) begin
            step(1'b0, 1'b0, '0);
            e = mq.pop_front();
            vectors++;
            if ({data_out_valid, data_out_first, data_out_last, data_out} !==
                {1'b1, k == 0, k == FR - 1, e}) begin
                miscompares++;
                $display("FAIL basic_out%0d: got v%b f%b l%b d%h, expected v1 f%b l%b d%h",
                         k, data_out_valid, data_out_first, data_out_last, data_out,
                         k == 0, k == FR - 1, e);
            end
        end
        step(1'b0, 1'b0, '0);
        vectors++;
        if ({data_out_valid, busy, data_count} !== '0) begin
            miscompares++;
            $display("FAIL basic_end: got v%b b%b cnt%0d, expected v0 b0 cnt0",
                     data_out_valid, busy, data_count);
        end
    endtask

    task automatic test_streaming;
        int wc = 0;
        int oc = 0;
        int cyc = 0;
        bit gap = 1'b0;
        bit started = 1'b0;
        logic [W-1:0] e;
        do_reset();
        while (oc < 40 && cyc < 200) begin
            if (wc < 40) begin
                step(1'b1, 1'b0, smp(wc));
                wc++;
            end else begin
                step(1'b0, 1'b0, '0);
            end
            cyc++;
            if (data_out_valid) begin
                vectors++;
                if (mq.size() == 0) begin
                    miscompares++;
                    $display("FAIL stream_extra: got output %h, expected none", data_out);
                end else begin
                    e = mq.pop_front();
                    if ({data_out, data_out_first, data_out_last} !==
                        {e, oc % FR == 0, oc % FR == FR - 1}) begin
                        miscompares++;
                        $display("FAIL stream_out%0d: got d%h f%b l%b, expected d%h f%b l%b",
                                 oc, data_out, data_out_first, data_out_last,
                                 e, oc % FR == 0, oc % FR == FR - 1);
                    end
                end
                if (oc < 39) begin
                    vectors++;
                    if (busy !== 1'b1) begin
                        miscompares++;
                        $display("FAIL stream_busy%0d: got %b, expected 1", oc, busy);
                    end
                end
                started = 1'b1;
                oc++;
            end else if (started) begin
                gap = 1'b1;
            end
        end
        vectors++;
        if (oc != 40 || gap || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL stream_summary: got outputs %0d gap %b ovf %b, expected 40 0 0",
                     oc, gap, overflow);
        end
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        vectors++;
        if ({data_count, busy, data_out_valid} !== '0) begin
            miscompares++;
            $display("FAIL stream_end: got cnt%0d b%b v%b, expected 0 0 0",
                     data_count, busy, data_out_valid);
        end
    endtask

    task automatic test_overflow;
        int oc = 0;
        logic [W-1:0] e;
        do_reset();
        for (int k = 0; k < 17; k++) begin
            data_in = smp(k);
            data_in_valid2 = 1'b1;
            @(posedge clk);
            #1;
        end
        data_in_valid2 = 1'b0;
        vectors++;
        if ({overflow2, data_count2} !== {1'b1, (AL+1)'(16)}) begin
            miscompares++;
            $display("FAIL ovf_set: got o%b cnt%0d, expected o1 cnt16",
                     overflow2, data_count2);
        end
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (data_out_valid2) begin
                e = smp(oc);
                vectors++;
                if (oc > 15 || {data_out2, data_out_first2, data_out_last2} !==
                    {e, oc == 0, oc == 15}) begin
                    miscompares++;
                    $display("FAIL ovf_out%0d: got d%h f%b l%b, expected d%h f%b l%b",
                             oc, data_out2, data_out_first2, data_out_last2,
                             e, oc == 0, oc == 15);
                end
                oc++;
            end
            vectors++;
            if (overflow2 !== 1'b1) begin
                miscompares++;
                $display("FAIL ovf_sticky: got %b, expected 1", overflow2);
            end
        end
        vectors++;
        if (oc != 16 || data_count2 !== '0) begin
            miscompares++;
            $display("FAIL ovf_end: got outputs %0d cnt%0d, expected 16 0", oc, data_count2);
        end
    endtask

    task automatic test_flush;
        logic [W-1:0] e;
        do_reset();
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, smp(k + 40));
        step(1'b0, 1'b1, '0);
        vectors++;
        if ({busy, data_out_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL flush_n1: got b%b v%b, expected b1 v0", busy, data_out_valid);
        end
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0, '0);
            e = mq.pop_front();
            vectors++;
            if ({data_out_valid, data_out_first, data_out_last, data_out} !==
                {1'b1, k == 0, k == 4, e}) begin
                miscompares++;
                $display("FAIL flush_out%0d: got v%b f%b l%b d%h, expected v1 f%b l%b d%h",
                         k, data_out_valid, data_out_first, data_out_last, data_out,
                         k == 0, k == 4, e);
            end
        end
        step(1'b0, 1'b0, '0);
        vectors++;
        if ({data_out_valid, busy, data_count} !== '0) begin
            miscompares++;
            $display("FAIL flush_end: got v%b b%b cnt%0d, expected 0 0 0",
                     data_out_valid, busy, data_count);
        end
        step(1'b0, 1'b1, '0);
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 1'b0, '0);
            vectors++;
            if ({data_out_valid, busy} !== 2'b00) begin
                miscompares++;
                $display("FAIL flush_empty: got v%b b%b, expected v0 b0",
                         data_out_valid, busy);
            end
        end
    endtask

    task automatic test_wrap;
        int wc = 0;
        int cyc = 0;
        int idle = 0;
        int opos = 0;
        int rem = 0;
        int oc = 0;
        bit v;
        logic [W-1:0] e;
        do_reset();
        while ((wc < 100 || idle < 4) && cyc < 2000) begin
            v = (wc < 100) && ($urandom_range(0, 99) < 60);
            if (v) begin
                step(1'b1, 1'b0, smp(wc + 200));
                wc++;
            end else begin
                step(1'b0, 1'b0, '0);
            end
            cyc++;
            if (!busy && !data_out_valid) idle++;
            else idle = 0;
            if (data_out_valid) begin
                vectors++;
                if (mq.size() == 0) begin
                    miscompares++;
                    $display("FAIL wrap_extra: got output %h, expected none", data_out);
                end else begin
                    e = mq.pop_front();
                    if ({data_out, data_out_first, data_out_last} !==
                        {e, opos == 0, opos == FR - 1}) begin
                        miscompares++;
                        $display("FAIL wrap_out: got d%h f%b l%b, expected d%h f%b l%b",
                                 data_out, data_out_first, data_out_last,
                                 e, opos == 0, opos == FR - 1);
                    end
                end
                opos = (opos + 1) % FR;
            end
        end
        rem = mq.size();
        vectors++;
        if (data_count !== (AL+1)'(rem) || opos != 0 || wc != 100) begin
            miscompares++;
            $display("FAIL wrap_resid: got cnt%0d pos%0d writes%0d, expected cnt%0d pos0 writes100",
                     data_count, opos, wc, rem);
        end
        step(1'b0, 1'b1, '0);
        for (int c = 0; c < rem + 4; c++) begin
            step(1'b0, 1'b0, '0);
            if (data_out_valid) begin
                vectors++;
                if (mq.size() == 0) begin
                    miscompares++;
                    $display("FAIL wrap_flush_extra: got output %h, expected none", data_out);
                end else begin
                    e = mq.pop_front();
                    if ({data_out, data_out_first, data_out_last} !==
                        {e, oc == 0, oc == rem - 1}) begin
                        miscompares++;
                        $display("FAIL wrap_flush%0d: got d%h f%b l%b, expected d%h f%b l%b",
                                 oc, data_out, data_out_first, data_out_last,
                                 e, oc == 0, oc == rem - 1);
                    end
                end
                oc++;
            end
        end
        vectors++;
        if (oc != rem || data_count !== '0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_end: got outputs %0d cnt%0d ovf%b, expected %0d 0 0",
                     oc, data_count, overflow, rem);
        end
    endtask

    task automatic test_reset_mid;
        int oc = 0;
        bit hit = 1'b0;
        logic [W-1:0] e;
        do_reset();
        for (int k = 0; k < FR; k++) step(1'b1, 1'b0, smp(k + 500));
        for (int c = 0; c < 20 && !hit; c++) begin
            step(1'b0, 1'b0, '0);
            if (data_out_valid) begin
                e = mq.pop_front();
                vectors++;
                if (data_out !== e) begin
                    miscompares++;
                    $display("FAIL rmid_pre%0d: got %h, expected %h", oc, data_out, e);
                end
                if (oc == 3) hit = 1'b1;
                oc++;
            end
        end
        vectors++;
        if (hit !== 1'b1) begin
            miscompares++;
            $display("FAIL rmid_reach: got %0d outputs, expected 4", oc);
        end
        rst = 1'b1;
        step(1'b0, 1'b0, '0);
        rst = 1'b0;
        mq.delete();
        vectors++;
        if ({data_out_valid, data_out_first, data_out_last, busy, overflow,
             data_count, data_out} !== '0) begin
            miscompares++;
            $display("FAIL rmid_reset: got v%b f%b l%b b%b o%b cnt%0d d%h, expected all 0",
                     data_out_valid, data_out_first, data_out_last, busy, overflow,
                     data_count, data_out);
        end
        for (int k = 0; k < FR; k++) step(1'b1, 1'b0, smp(k + 700));
        oc = 0;
        for (int c = 0; c < 20; c++) begin
            step(1'b0, 1'b0, '0);
            if (data_out_valid) begin
                vectors++;
                if (mq.size() == 0) begin
                    miscompares++;
                    $display("FAIL rmid_extra: got output %h, expected none", data_out);
                end else begin
                    e = mq.pop_front();
                    if ({data_out, data_out_first, data_out_last} !==
                        {e, oc == 0, oc == FR - 1}) begin
                        miscompares++;
                        $display("FAIL rmid_out%0d: got d%h f%b l%b, expected d%h f%b l%b",
                                 oc, data_out, data_out_first, data_out_last,
                                 e, oc == 0, oc == FR - 1);
                    end
                end
                oc++;
            end
        end
        vectors++;
        if (oc != FR || data_count !== '0) begin
            miscompares++;
            $display("FAIL rmid_end: got outputs %0d cnt%0d, expected 8 0", oc, data_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_streaming();
        test_overflow();
        test_flush();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
